// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: arbiter state encoding, grant encoding and EtherType values.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_SEND     = 3'd2,
        ST_WAIT_END = 3'd3,
        ST_GAP      = 3'd4
    } arb_state_t;

    typedef enum logic {
        GNT_ARP = 1'b0,
        GNT_IP  = 1'b1
    } gnt_t;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// Bundle of the ARP source, IP source and MAC TX signals around mac_tx_arbiter.
// Handshake: a source holds *_tx_req until its one-cycle *_tx_ack; bytes move while *_tx_ready is high.
interface mac_tx_arbiter_if;
    import eth_pkg::*;

    logic        arp_tx_req;
    logic        arp_tx_ready;
    logic [7:0]  arp_tx_data;
    logic        arp_tx_end;
    logic        arp_tx_ack;
    logic        arp_data_req;
    logic        ip_tx_req;
    logic        ip_tx_ready;
    logic [7:0]  ip_tx_data;
    logic        ip_tx_end;
    logic        ip_tx_ack;
    logic        ip_data_req;
    logic        mac_tx_req;
    logic        mac_tx_ack;
    logic        mac_data_req;
    logic        mac_send_end;
    logic        mac_tx_ready;
    logic [7:0]  mac_tx_data;
    logic        mac_tx_end;
    logic [15:0] mac_frame_type;
    logic        arb_busy;
    logic        arb_timeout;
    arb_state_t  dbg_state;

    // Arbiter view.
    modport slave (
        input  arp_tx_req, arp_tx_ready, arp_tx_data, arp_tx_end,
        input  ip_tx_req, ip_tx_ready, ip_tx_data, ip_tx_end,
        input  mac_tx_ack, mac_data_req, mac_send_end,
        output arp_tx_ack, arp_data_req, ip_tx_ack, ip_data_req,
        output mac_tx_req, mac_tx_ready, mac_tx_data, mac_tx_end, mac_frame_type,
        output arb_busy, arb_timeout, dbg_state
    );

    // Surrounding sources and MAC view.
    modport master (
        output arp_tx_req, arp_tx_ready, arp_tx_data, arp_tx_end,
        output ip_tx_req, ip_tx_ready, ip_tx_data, ip_tx_end,
        output mac_tx_ack, mac_data_req, mac_send_end,
        input  arp_tx_ack, arp_data_req, ip_tx_ack, ip_data_req,
        input  mac_tx_req, mac_tx_ready, mac_tx_data, mac_tx_end, mac_frame_type,
        input  arb_busy, arb_timeout, dbg_state
    );

endinterface

// File: rtl/mac_tx_arb_sel.sv
// Grant selection between ARP and IP requests.
// MAC_TX_ARB_ROUND_ROBIN_EN selects round-robin; otherwise ARP has fixed priority.
module mac_tx_arb_sel
    import eth_pkg::*;
(
    input  logic arp_req,
    input  logic ip_req,
`ifdef MAC_TX_ARB_ROUND_ROBIN_EN
    input  gnt_t last_served,
`endif
    output gnt_t gnt
);

    always_comb begin
        gnt = GNT_ARP;
        if (arp_req && ip_req) begin
`ifdef MAC_TX_ARB_ROUND_ROBIN_EN
            if (last_served == GNT_ARP) gnt = GNT_IP;
            else                        gnt = GNT_ARP;
`else
            gnt = GNT_ARP;
`endif
        end else if (ip_req) begin
            gnt = GNT_IP;
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Shares the MAC TX path between ARP and IP: grant, MAC req/ack, data steering, IFG holdoff, watchdog.
// Define MAC_TX_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of ARP-first priority.
module mac_tx_arbiter
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic            clk,
    input  logic            rstn,
    mac_tx_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES);
    // The abort fires in the TIMEOUT_CYCLES-th cycle of a guarded state (counter starts at 0).
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    arb_state_t       state_q, state_d;
    gnt_t             gnt_q, gnt_d, sel_gnt;
    logic             gnt_vld_q, gnt_vld_d;
    logic [CNT_W-1:0] cnt_q;
    logic             ack_pulse, timeout, watchdog, steer;
    logic             g_req, g_ready, g_end;
    logic [7:0]       g_data;

`ifdef MAC_TX_ARB_ROUND_ROBIN_EN
    gnt_t last_served_q;

    always_ff @(posedge clk) begin
        if (rstn)           last_served_q <= GNT_IP;
        else if (ack_pulse) last_served_q <= gnt_q;
    end
`endif

    mac_tx_arb_sel u_sel (
        .arp_req     (bus.arp_tx_req),
        .ip_req      (bus.ip_tx_req),
`ifdef MAC_TX_ARB_ROUND_ROBIN_EN
        .last_served (last_served_q),
`endif
        .gnt         (sel_gnt)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= ST_IDLE;
            gnt_q     <= GNT_ARP;
            gnt_vld_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            if (state_d != state_q)  cnt_q <= '0;
            else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        if (gnt_q == GNT_ARP) begin
            g_req   = bus.arp_tx_req;
            g_ready = bus.arp_tx_ready;
            g_data  = bus.arp_tx_data;
            g_end   = bus.arp_tx_end;
        end else begin
            g_req   = bus.ip_tx_req;
            g_ready = bus.ip_tx_ready;
            g_data  = bus.ip_tx_data;
            g_end   = bus.ip_tx_end;
        end
    end

    assign watchdog = (cnt_q >= TO_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_vld_d = gnt_vld_q;
        ack_pulse = 1'b0;
        timeout   = 1'b0;
        unique case (state_q)
            // Grant is registered first; REQ follows one cycle later.
            ST_IDLE: begin
                if (gnt_vld_q) begin
                    state_d = ST_REQ;
                end else if (bus.arp_tx_req || bus.ip_tx_req) begin
                    gnt_d     = sel_gnt;
                    gnt_vld_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.mac_tx_ack) begin
                    ack_pulse = 1'b1;
                    state_d   = ST_SEND;
                end else if (!g_req) begin
                    gnt_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (watchdog) begin
                    timeout = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_SEND: begin
                if (bus.mac_send_end) begin
                    state_d = ST_GAP;
                end else if (g_ready && g_end) begin
                    state_d = ST_WAIT_END;
                end else if (watchdog) begin
                    timeout = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_WAIT_END: begin
                if (bus.mac_send_end) begin
                    state_d = ST_GAP;
                end else if (watchdog) begin
                    timeout = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q >= IFG_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_GAP) gnt_vld_d = 1'b0;
    end

    always_comb begin
        steer              = (state_q == ST_SEND) || (state_q == ST_WAIT_END);
        bus.mac_tx_req     = (state_q == ST_REQ);
        bus.mac_tx_ready   = (state_q == ST_SEND) && g_ready;
        bus.mac_tx_data    = steer ? g_data : 8'h00;
        bus.mac_tx_end     = steer && g_end;
        bus.arp_data_req   = steer && (gnt_q == GNT_ARP) && bus.mac_data_req;
        bus.ip_data_req    = steer && (gnt_q == GNT_IP) && bus.mac_data_req;
        bus.arp_tx_ack     = ack_pulse && (gnt_q == GNT_ARP);
        bus.ip_tx_ack      = ack_pulse && (gnt_q == GNT_IP);
        bus.mac_frame_type = 16'h0000;
        if (steer || (state_q == ST_REQ))
            bus.mac_frame_type = (gnt_q == GNT_ARP) ? ETH_TYPE_ARP : ETH_TYPE_IP;
        bus.arb_busy       = (state_q != ST_IDLE);
        bus.arb_timeout    = timeout;
        bus.dbg_state      = state_q;
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: mux vector table plus hand sequences for arbitration,
// inter-frame gap, watchdog, ack/drop race and mid-frame reset.
module tb_mac_tx_arbiter;
  import eth_pkg::*;

  localparam int IFG = 12;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  mac_tx_arbiter_if bus ();

  mac_tx_arbiter #(
    .IFG_CYCLES     (IFG),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (16)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       arp_r;
    logic [7:0] arp_d;
    logic       arp_e;
    logic       ip_r;
    logic [7:0] ip_d;
    logic       ip_e;
    logic       dreq;
    logic       e_rdy;
    logic [7:0] e_data;
    logic       e_end;
    logic       e_adreq;
    logic       e_idreq;
  } mux_vec_t;

  mux_vec_t vecs[5];
  logic [7:0]  exp_q[$];
  logic [15:0] type_q[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!bus.mac_tx_req && n < 60) begin
      tick(); #1; n++;
    end
    chk(name, 32'(bus.mac_tx_req), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.dbg_state != ST_IDLE && n < 60) begin
      tick(); #1; n++;
    end
    chk(name, 32'(bus.dbg_state), 32'(ST_IDLE));
  endtask

  function automatic logic [31:0] out_flags();
    return 32'({bus.arp_tx_ack, bus.arp_data_req, bus.ip_tx_ack, bus.ip_data_req,
                bus.mac_tx_req, bus.mac_tx_ready, bus.mac_tx_end, bus.arb_busy, bus.arb_timeout});
  endfunction

  task automatic clear_inputs();
    bus.arp_tx_req = 0; bus.arp_tx_ready = 0; bus.arp_tx_data = 8'h00; bus.arp_tx_end = 0;
    bus.ip_tx_req  = 0; bus.ip_tx_ready  = 0; bus.ip_tx_data  = 8'h00; bus.ip_tx_end  = 0;
    bus.mac_tx_ack = 0; bus.mac_data_req = 0; bus.mac_send_end = 0;
  endtask

  initial begin
    logic [15:0] exp_t;
    logic [15:0] got_t;
    logic [7:0]  b;
    int gap, early, acks, nbytes, adreq_seen;

    vecs[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1,  1'b0, 8'h22, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'h33, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0,  1'b1, 8'h44, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h66, 1'b0, 1'b1,  1'b1, 8'h66, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'h77, 1'b0, 1'b0, 8'h88, 1'b1, 1'b0,  1'b0, 8'h88, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h99, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};

    // Reset
    clear_inputs();
    rstn = 1'b1;
    repeat (3) tick();
    rstn = 1'b0;
    #1;
    chk("reset_flags", out_flags(), 32'd0);
    chk("reset_frame_type", 32'(bus.mac_frame_type), 32'd0);
    chk("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // IP alone: grant, REQ two cycles later, ack pulse, mux table, 60-byte stream
    tick(); bus.ip_tx_req = 1; #1;
    chk("ip_req_c0", 32'(bus.mac_tx_req), 32'd0);
    tick(); #1;
    chk("ip_req_c1", 32'(bus.mac_tx_req), 32'd0);
    chk("ip_busy_c1", 32'(bus.arb_busy), 32'd0);
    tick(); #1;
    chk("ip_req_c2", 32'(bus.mac_tx_req), 32'd1);
    chk("ip_frame_type", 32'(bus.mac_frame_type), 32'h0800);
    chk("ip_busy_c2", 32'(bus.arb_busy), 32'd1);
    tick(); bus.mac_tx_ack = 1; #1;
    chk("ip_ack", 32'(bus.ip_tx_ack), 32'd1);
    chk("ip_no_arp_ack", 32'(bus.arp_tx_ack), 32'd0);
    tick(); bus.mac_tx_ack = 0; bus.ip_tx_req = 0; #1;
    chk("ip_ack_one_cycle", 32'(bus.ip_tx_ack), 32'd0);
    chk("ip_req_dropped", 32'(bus.mac_tx_req), 32'd0);
    chk("ip_state_send", 32'(bus.dbg_state), 32'(ST_SEND));

    for (int i = 0; i < 5; i++) begin
      tick();
      bus.arp_tx_ready = vecs[i].arp_r; bus.arp_tx_data = vecs[i].arp_d; bus.arp_tx_end = vecs[i].arp_e;
      bus.ip_tx_ready  = vecs[i].ip_r;  bus.ip_tx_data  = vecs[i].ip_d;  bus.ip_tx_end  = vecs[i].ip_e;
      bus.mac_data_req = vecs[i].dreq;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(bus.mac_tx_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_data", i), 32'(bus.mac_tx_data), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d_end", i), 32'(bus.mac_tx_end), 32'(vecs[i].e_end));
      chk($sformatf("vec%0d_arp_dreq", i), 32'(bus.arp_data_req), 32'(vecs[i].e_adreq));
      chk($sformatf("vec%0d_ip_dreq", i), 32'(bus.ip_data_req), 32'(vecs[i].e_idreq));
    end

    nbytes = 0;
    adreq_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      b = 8'(i * 7 + 3);
      bus.ip_tx_ready = 1; bus.ip_tx_data = b; bus.ip_tx_end = (i == 59);
      bus.arp_tx_ready = 1; bus.arp_tx_data = 8'hEE; bus.arp_tx_end = 0;
      bus.mac_data_req = 1;
      exp_q.push_back(b);
      #1;
      if (bus.arp_data_req) adreq_seen++;
      if (bus.mac_tx_ready && exp_q.size() > 0) begin
        chk("stream_byte", 32'(bus.mac_tx_data), 32'(exp_q.pop_front()));
        nbytes++;
      end
    end
    chk("stream_count", 32'(nbytes), 32'd60);
    chk("stream_arp_dreq", 32'(adreq_seen), 32'd0);
    tick(); bus.ip_tx_end = 0; bus.mac_data_req = 0; bus.arp_tx_ready = 0; #1;
    chk("wait_end_state", 32'(bus.dbg_state), 32'(ST_WAIT_END));
    chk("wait_end_ready_low", 32'(bus.mac_tx_ready), 32'd0);
    tick(); bus.ip_tx_ready = 0; bus.mac_send_end = 1; #1;
    tick(); bus.mac_send_end = 0; #1;
    chk("gap_state", 32'(bus.dbg_state), 32'(ST_GAP));
    chk("gap_frame_type", 32'(bus.mac_frame_type), 32'd0);
    gap = 0;
    while (bus.dbg_state == ST_GAP && gap < 50) begin
      gap++; tick(); #1;
    end
    chk("gap_length", 32'(gap), 32'(IFG + 1));
    chk("gap_to_idle", 32'(bus.dbg_state), 32'(ST_IDLE));

    // Both sources requesting for three back-to-back frames
`ifdef MAC_TX_ARB_ROUND_ROBIN_EN
    type_q = '{ETH_TYPE_ARP, ETH_TYPE_IP, ETH_TYPE_ARP};
`else
    type_q = '{ETH_TYPE_ARP, ETH_TYPE_ARP, ETH_TYPE_ARP};
`endif
    tick(); bus.arp_tx_req = 1; bus.ip_tx_req = 1; #1;
    for (int f = 0; f < 3; f++) begin
      wait_req("order_req");
      exp_t = type_q.pop_front();
      chk("order_frame_type", 32'(bus.mac_frame_type), 32'(exp_t));
      tick(); bus.mac_tx_ack = 1;
      if (f == 2) begin bus.arp_tx_req = 0; bus.ip_tx_req = 0; end
      #1;
      got_t = bus.arp_tx_ack ? ETH_TYPE_ARP : (bus.ip_tx_ack ? ETH_TYPE_IP : 16'h0000);
      chk("order_grant", 32'(got_t), 32'(exp_t));
      chk("order_ack_onehot", 32'(bus.arp_tx_ack & bus.ip_tx_ack), 32'd0);
      tick(); bus.mac_tx_ack = 0;
      bus.arp_tx_ready = 1; bus.arp_tx_end = 1; bus.ip_tx_ready = 1; bus.ip_tx_end = 1; #1;
      tick(); bus.arp_tx_ready = 0; bus.arp_tx_end = 0; bus.ip_tx_ready = 0; bus.ip_tx_end = 0;
      bus.mac_send_end = 1; #1;
      tick(); bus.mac_send_end = 0; #1;
      if (f < 2) begin
        gap = 0;
        while (!bus.mac_tx_req && gap < 60) begin
          gap++; tick(); #1;
        end
        chk("order_ifg", 32'(gap >= IFG), 32'd1);
      end
    end
    wait_idle("order_idle");

    // Watchdog: ack withheld in REQ
    tick(); bus.arp_tx_req = 1; #1;
    wait_req("tmo_req");
    early = 0;
    acks = 0;
    for (int k = 1; k <= TMO; k++) begin
      if (k > 1) begin tick(); #1; end
      if (bus.arb_timeout && k < TMO) early++;
      if (bus.arp_tx_ack || bus.ip_tx_ack) acks++;
      if (k == TMO) chk("tmo_pulse", 32'(bus.arb_timeout), 32'd1);
    end
    tick(); bus.arp_tx_req = 0; #1;
    chk("tmo_early", 32'(early), 32'd0);
    chk("tmo_no_ack", 32'(acks), 32'd0);
    chk("tmo_req_low", 32'(bus.mac_tx_req), 32'd0);
    chk("tmo_pulse_end", 32'(bus.arb_timeout), 32'd0);
    chk("tmo_gap", 32'(bus.dbg_state), 32'(ST_GAP));
    wait_idle("tmo_idle");

    // ARP req drops on the same cycle as mac_tx_ack
    tick(); bus.arp_tx_req = 1; #1;
    wait_req("race_req");
    tick(); bus.arp_tx_req = 0; bus.mac_tx_ack = 1; #1;
    chk("race_ack", 32'(bus.arp_tx_ack), 32'd1);
    tick(); bus.mac_tx_ack = 0; bus.arp_tx_ready = 1; bus.arp_tx_data = 8'hAA; bus.mac_data_req = 1; #1;
    chk("race_send", 32'(bus.dbg_state), 32'(ST_SEND));
    chk("race_arp_dreq", 32'(bus.arp_data_req), 32'd1);
    chk("race_data", 32'(bus.mac_tx_data), 32'h00AA);

    // Reset mid-SEND, then a fresh IP frame
    tick(); rstn = 1'b1; #1;
    tick(); #1;
    chk("midrst_flags", out_flags(), 32'd0);
    chk("midrst_data", 32'(bus.mac_tx_data), 32'd0);
    chk("midrst_frame_type", 32'(bus.mac_frame_type), 32'd0);
    tick(); rstn = 1'b0; clear_inputs(); #1;
    chk("midrst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    tick(); bus.ip_tx_req = 1; #1;
    wait_req("post_rst_req");
    chk("post_rst_type", 32'(bus.mac_frame_type), 32'h0800);
    tick(); bus.mac_tx_ack = 1; #1;
    chk("post_rst_ack", 32'(bus.ip_tx_ack), 32'd1);
    tick(); bus.mac_tx_ack = 0; bus.ip_tx_req = 0;
    bus.ip_tx_ready = 1; bus.ip_tx_data = 8'h5A; bus.ip_tx_end = 1; bus.mac_data_req = 1; #1;
    chk("post_rst_data", 32'(bus.mac_tx_data), 32'h005A);
    chk("post_rst_ip_dreq", 32'(bus.ip_data_req), 32'd1);
    tick(); clear_inputs(); bus.mac_send_end = 1; #1;
    chk("post_rst_wait_end", 32'(bus.dbg_state), 32'(ST_WAIT_END));
    tick(); bus.mac_send_end = 0; #1;
    chk("post_rst_gap", 32'(bus.dbg_state), 32'(ST_GAP));
    wait_idle("post_rst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
- Shares the single MAC TX path between two frame sources: the ARP engine and the IP layer.
- Grants one source at a time and runs the MAC request/ack handshake on its behalf.
- While a source is granted, steers that source's ready/data/end onto the MAC and routes mac_data_req back to it.
- Enforces an inter-frame holdoff and a watchdog timeout. Sits between arp_tx/ip_layer and mac_tx in the Ethernet top.

Parameters:
- IFG_CYCLES, 12, idle cycles after mac_send_end before the next grant (0 allowed).
- TIMEOUT_CYCLES, 65535, maximum cycles spent in REQ, SEND or WAIT_END before forced abort.
- CNT_W, 16, width of the shared gap/timeout counter; TIMEOUT_CYCLES must be < 2^CNT_W.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous, active-high reset (name kept per codebase)
- arp_tx_req  in  1  ARP frame request (level, held until ack)
- arp_tx_ready  in  1  ARP data valid
- arp_tx_data  in  8  ARP byte
- arp_tx_end  in  1  ARP last byte
- arp_tx_ack  out  1  one-cycle grant acknowledge to ARP
- arp_data_req  out  1  mac_data_req routed to ARP while granted
- ip_tx_req / ip_tx_ready / ip_tx_data[8] / ip_tx_end  in  IP source equivalents
- ip_tx_ack  out  1  one-cycle grant acknowledge to IP
- ip_data_req  out  1  mac_data_req routed to IP while granted
- mac_tx_req  out  1  request to MAC
- mac_tx_ack  in  1  MAC accepted request
- mac_data_req  in  1  MAC requests payload bytes
- mac_send_end  in  1  MAC frame fully transmitted
- mac_tx_ready  out  1  muxed data valid
- mac_tx_data  out  8  muxed byte
- mac_tx_end  out  1  muxed last byte
- mac_frame_type  out  16  16'h0806 when ARP is granted, 16'h0800 when IP is granted, 0 otherwise
- arb_busy  out  1  high in every state except IDLE
- arb_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset:
  - State goes to IDLE; grant is cleared; counter is 0.
  - All outputs are 0, including mac_frame_type = 0.
  - Reset mid-frame aborts immediately; no ack and no timeout pulse are emitted.
- FSM states: IDLE, REQ, SEND, WAIT_END, GAP.
- IDLE:
  - If any request is high, register the grant (arbitration rule below) and go to REQ on the next cycle.
  - No request: stay in IDLE.
- REQ:
  - mac_tx_req = 1.
  - On mac_tx_ack: pulse <granted>_tx_ack for exactly one cycle, drop mac_tx_req, go to SEND.
  - If the granted req drops before mac_tx_ack: clear the grant, return to IDLE, no ack.
  - If mac_tx_ack and the req drop occur in the same cycle, the ack wins.
- SEND:
  - Output mux is combinational on the registered grant: mac_tx_ready/data/end = granted source's ready/data/end; <granted>_data_req = mac_data_req.
  - The ungranted source's data_req is 0.
  - Granted end seen while ready is high: go to WAIT_END.
  - mac_send_end seen first: go to GAP.
- WAIT_END:
  - Mux is held; mac_tx_ready = 0.
  - mac_send_end: go to GAP.
- GAP:
  - Grant is cleared; counter counts IFG_CYCLES, then go to IDLE.
  - IFG_CYCLES = 0 means one cycle in GAP.
- Watchdog:
  - The counter resets on each state entry.
  - If the counter reaches TIMEOUT_CYCLES in REQ, SEND or WAIT_END: pulse arb_timeout, drop mac_tx_req, go to GAP.
- Requests arriving in any non-IDLE state are held off. They are not lost while the requester keeps them high.
- mac_frame_type is valid from REQ entry until GAP entry.
- Counter saturates at its maximum value; it never wraps.

Optional Feature:
- Macro: MAC_TX_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A 1-bit last_served register (reset = IP) gives priority to the other source when both requests are high. last_served updates only on an ack.
- Undefined: fixed priority, ARP over IP. last_served logic is absent.
- Either way, a single request is granted immediately.

Decomposition:
- Shared package eth_pkg holds:
  - state encodings
  - ETH_TYPE_ARP = 16'h0806 and ETH_TYPE_IP = 16'h0800
  - grant encoding GNT_ARP / GNT_IP
- One natural sub-module: mac_tx_arb_sel. It is the grant-selection logic (priority or round-robin), instantiated by the FSM in IDLE.

Test Plan:
- ip_tx_req alone → mac_tx_req rises 2 cycles later. mac_tx_ack → ip_tx_ack pulse of 1 cycle, mac_frame_type = 16'h0800. A 60-byte stream passes unaltered; arp_data_req stays 0.
- ARP and IP requests together for three back-to-back frames:
  - Fixed priority: order ARP, ARP, ARP.
  - With MAC_TX_ARB_ROUND_ROBIN_EN: order ARP, IP, ARP.
  - Each grant is separated by at least IFG_CYCLES = 12 idle cycles after mac_send_end.
- mac_tx_ack withheld, TIMEOUT_CYCLES = 100 → arb_timeout pulses at cycle 100 of REQ, mac_tx_req drops, no requester ack, state returns to IDLE after GAP.
- ARP req dropped in REQ on the same cycle as mac_tx_ack → arp_tx_ack is still pulsed, SEND is entered.
- rstn asserted mid-SEND → next cycle all outputs are 0, arb_busy = 0, no arb_timeout; a fresh IP request then completes normally.
